// File: rtl/uart_cmd_defs.sv
// Shared definitions for the UART command sequencer: FSM state encoding,
// status codes returned to the PC, and the default response timeout.
package uart_cmd_defs;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ADDR = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_RSP  = 3'd3,
    S_TX_B0     = 3'd4,
    S_WAIT_TX0  = 3'd5,
    S_TX_B1     = 3'd6,
    S_WAIT_TX1  = 3'd7
  } state_e;

  localparam logic [7:0] ST_BAD_ADDR = 8'hFE;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFF;

  // 50 ms at 50 MHz
  localparam int TIMEOUT_CYCLES_DEF = 2500000;

endpackage

// File: rtl/uart_cmd_controller_timer.sv
// uart_cmd_timer: saturating cycle counter with a one-cycle-early expiry
// flag, so the owner can act on the LIMIT-th cycle spent waiting.
module uart_cmd_timer
  import uart_cmd_defs::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count while enabled and stick at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: collects {cmd, addr} from uart_rx, issues a request to
// the addressed unit, and returns {status, data} through uart_tx.
// Optional feature macro: UART_CMD_TIMEOUT_EN (inter-byte and response timeout).
module uart_cmd_controller
  import uart_cmd_defs::*;
#(
  parameter int NUM_UNITS      = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Req_Valid,
  output logic [ADDR_W-1:0] o_Req_Addr,
  output logic [7:0]        o_Req_Cmd,
  input  logic              i_Rsp_Valid,
  input  logic [7:0]        i_Rsp_Code,
  input  logic [7:0]        i_Rsp_Data,
  output logic              o_Busy
);

  if ((2 ** ADDR_W) < NUM_UNITS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_cmd_controller: ADDR_W too narrow or TIMEOUT_CYCLES < 1");
  end

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        code_q, code_d;
  logic [7:0]        data_q, data_d;
  logic              to_expire;

`ifdef UART_CMD_TIMEOUT_EN
  logic to_wait;
  assign to_wait = (state_q == S_WAIT_ADDR) || (state_q == S_WAIT_RSP);

  // Timer runs only in the two waiting states and restarts from zero on entry
  uart_cmd_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .clr_i    (!to_wait),
    .en_i     (to_wait),
    .expire_o (to_expire)
  );
`else
  assign to_expire = 1'b0;
`endif

  // Next-state and output decode; valid inputs take priority over expiry
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    code_d      = code_q;
    data_d      = data_q;
    o_Req_Valid = 1'b0;
    o_Tx_DV     = 1'b0;
    o_Tx_Byte   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          state_d = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        if (i_Rx_DV) begin
          addr_d = i_Rx_Byte[ADDR_W-1:0];
          // full-byte compare so high bits can't alias onto a valid unit
          if ({24'd0, i_Rx_Byte} >= 32'(NUM_UNITS)) begin
            code_d  = ST_BAD_ADDR;
            data_d  = 8'h00;
            state_d = S_TX_B0;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (to_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        o_Req_Valid = 1'b1;
        state_d     = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (i_Rsp_Valid) begin
          code_d  = i_Rsp_Code;
          data_d  = i_Rsp_Data;
          state_d = S_TX_B0;
        end else if (to_expire) begin
          code_d  = ST_TIMEOUT;
          data_d  = 8'h00;
          state_d = S_TX_B0;
        end
      end
      S_TX_B0: begin
        o_Tx_Byte = code_q;
        if (!i_Tx_Active) begin
          o_Tx_DV = 1'b1;
          state_d = S_WAIT_TX0;
        end
      end
      S_WAIT_TX0: begin
        o_Tx_Byte = code_q;
        if (i_Tx_Done) state_d = S_TX_B1;
      end
      S_TX_B1: begin
        o_Tx_Byte = data_q;
        if (!i_Tx_Active) begin
          o_Tx_DV = 1'b1;
          state_d = S_WAIT_TX1;
        end
      end
      S_WAIT_TX1: begin
        o_Tx_Byte = data_q;
        if (i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      addr_q  <= '0;
      code_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  assign o_Req_Addr = addr_q;
  assign o_Req_Cmd  = cmd_q;
  assign o_Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: behavioural uart_tx and sensor-unit models,
// randomized transactions checked against a rule-level reference.
module tb_uart_cmd_controller;

  localparam int NUM_UNITS = 32;
  localparam int ADDR_W    = 5;
  localparam int TO        = 100;

  logic              i_Clock = 1'b0;
  logic              i_Reset = 1'b1;
  logic              i_Rx_DV = 1'b0;
  logic [7:0]        i_Rx_Byte = 8'h00;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active = 1'b0;
  logic              i_Tx_Done = 1'b0;
  logic              o_Req_Valid;
  logic [ADDR_W-1:0] o_Req_Addr;
  logic [7:0]        o_Req_Cmd;
  logic              i_Rsp_Valid = 1'b0;
  logic [7:0]        i_Rsp_Code = 8'h00;
  logic [7:0]        i_Rsp_Data = 8'h00;
  logic              o_Busy;

  int errors = 0;
  int checks = 0;

  always #5 i_Clock = ~i_Clock;

  uart_cmd_controller #(
    .NUM_UNITS(NUM_UNITS), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done(i_Tx_Done), .o_Req_Valid(o_Req_Valid), .o_Req_Addr(o_Req_Addr),
    .o_Req_Cmd(o_Req_Cmd), .i_Rsp_Valid(i_Rsp_Valid), .i_Rsp_Code(i_Rsp_Code),
    .i_Rsp_Data(i_Rsp_Data), .o_Busy(o_Busy)
  );

  // ---------------- uart_tx model ----------------
  int         tx_len = 3;
  bit         ext_busy = 1'b0;
  bit         force_done = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] tx_cur = 8'h00;
  logic [7:0] tx_q[$];

  initial begin : tx_model
    logic       dv_s;
    logic [7:0] b_s;
    forever begin
      @(negedge i_Clock);
      dv_s = o_Tx_DV;
      b_s  = o_Tx_Byte;
      if (tx_cnt > 0) begin
        checks++;
        if (o_Tx_DV !== 1'b0 || o_Tx_Byte !== tx_cur) begin
          errors++;
          $display("FAIL tx_hold: dv=%b byte=%02h, required dv=0 byte=%02h", o_Tx_DV, o_Tx_Byte, tx_cur);
        end
      end
      @(posedge i_Clock); #1;
      i_Tx_Done  = force_done;
      force_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) i_Tx_Done = 1'b1;
      end else if (dv_s === 1'b1) begin
        tx_q.push_back(b_s);
        tx_cur = b_s;
        tx_cnt = tx_len;
      end
      i_Tx_Active = (tx_cnt > 0) || ext_busy;
    end
  end

  // ---------------- sensor unit model ----------------
  typedef struct packed {
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } req_t;

  int         rsp_lat = 1;
  bit         rsp_en = 1'b1;
  bit         force_rsp = 1'b0;
  int         rsp_cnt = 0;
  logic [7:0] nxt_code = 8'h00;
  logic [7:0] nxt_data = 8'h00;
  req_t       req_q[$];

  initial begin : unit_model
    logic rv_s;
    bit   fire;
    forever begin
      @(negedge i_Clock);
      rv_s = o_Req_Valid;
      if (o_Req_Valid === 1'b1) req_q.push_back({o_Req_Cmd, o_Req_Addr});
      @(posedge i_Clock); #1;
      fire = force_rsp;
      force_rsp = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) fire = 1'b1;
      end
      if (rv_s === 1'b1 && rsp_en) begin
        if (rsp_lat <= 1) fire = 1'b1;
        else              rsp_cnt = rsp_lat - 1;
      end
      i_Rsp_Valid = fire;
      // garbage on the data lines when not valid: must never be captured
      i_Rsp_Code  = fire ? nxt_code : 8'($urandom);
      i_Rsp_Data  = fire ? nxt_data : 8'($urandom);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick(1);
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while ((o_Busy !== 1'b0 || tx_cnt != 0) && n < 3000);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, o_Busy, n);
    end
    tick(1);
  endtask

  // Reference: what the PC must see for one {cmd, addr} request
  function automatic void ref_txn(input logic [7:0] addr, input logic [7:0] code,
                                  input logic [7:0] data, input int lat, input bit answers,
                                  output bit issue, output logic [7:0] b0, output logic [7:0] b1);
    issue = (int'(addr) < NUM_UNITS);
    b0 = code;
    b1 = data;
    if (!issue) begin
      b0 = 8'hFE; b1 = 8'h00;
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (!answers || lat > TO) begin
      b0 = 8'hFF; b1 = 8'h00;
    end
`endif
  endfunction

  task automatic run_txn(input string nm, input logic [7:0] cmd, input logic [7:0] addr,
                         input int lat, input logic [7:0] code, input logic [7:0] data);
    bit         issue;
    logic [7:0] b0, b1;
    req_t       exp_r;
    nxt_code = code;
    nxt_data = data;
    rsp_lat  = lat;
    req_q.delete();
    tx_q.delete();
    send(cmd);
    send(addr);
    wait_idle(nm);
    ref_txn(addr, code, data, lat, 1'b1, issue, b0, b1);
    exp_r = {cmd, addr[ADDR_W-1:0]};
    checks++;
    if (req_q.size() != (issue ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_req_count: got %0d, required %0d", nm, req_q.size(), issue ? 1 : 0);
    end else if (issue) begin
      checks++;
      if (req_q[0] !== exp_r) begin
        errors++;
        $display("FAIL %s_req: cmd=%02h addr=%0d, required cmd=%02h addr=%0d",
                 nm, req_q[0].cmd, req_q[0].addr, exp_r.cmd, exp_r.addr);
      end
    end
    checks++;
    if (tx_q.size() != 2) begin
      errors++;
      $display("FAIL %s_tx_count: got %0d bytes, required 2", nm, tx_q.size());
    end else begin
      checks++;
      if (tx_q[0] !== b0 || tx_q[1] !== b1) begin
        errors++;
        $display("FAIL %s_tx: got %02h %02h, required %02h %02h", nm, tx_q[0], tx_q[1], b0, b1);
      end
    end
  endtask

  task automatic check_quiet(input string nm);
    checks++;
    if (o_Tx_DV !== 1'b0 || o_Tx_Byte !== 8'h00 || o_Req_Valid !== 1'b0 ||
        o_Req_Addr !== '0 || o_Req_Cmd !== 8'h00 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: dv=%b byte=%02h req=%b addr=%0d cmd=%02h busy=%b, required all 0",
               nm, o_Tx_DV, o_Tx_Byte, o_Req_Valid, o_Req_Addr, o_Req_Cmd, o_Busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_Reset = 1'b1;
    tick(3);
    @(negedge i_Clock);
    check_quiet("reset_state");
    tick(1);
    i_Reset = 1'b0;
    tick(1);
  endtask

  task automatic test_valid();
    tx_len = 3;
    run_txn("valid", 8'h01, 8'h03, 4, 8'h00, 8'h1A);
  endtask

  task automatic test_bad_addr();
    run_txn("bad_40", 8'h02, 8'h40, 2, 8'h12, 8'h34);
    run_txn("edge_31", 8'h03, 8'd31, 1, 8'h5A, 8'hA5);
    run_txn("edge_32", 8'h04, 8'd32, 1, 8'h5A, 8'hA5);
    run_txn("bad_ff", 8'h05, 8'hFF, 1, 8'h5A, 8'hA5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      tx_len = $urandom_range(1, 5);
      run_txn("rand", 8'($urandom), 8'($urandom_range(0, 63)), $urandom_range(1, 8),
              8'($urandom), 8'($urandom));
      tick($urandom_range(0, 3));
    end
  endtask

  task automatic test_busy_drop();
    int n = 0;
    tx_len = 10;
    nxt_code = 8'h77; nxt_data = 8'h88; rsp_lat = 2;
    req_q.delete(); tx_q.delete();
    send(8'h11);
    send(8'h04);
    while (tx_q.size() == 0 && n < 500) begin @(negedge i_Clock); n++; end
    tick(1);
    send(8'h55);
    wait_idle("busy_drop");
    tick(3);
    checks++;
    if (o_Busy !== 1'b0 || req_q.size() != 1 || tx_q.size() != 2) begin
      errors++;
      $display("FAIL busy_drop: busy=%b reqs=%0d tx=%0d, required 0/1/2", o_Busy, req_q.size(), tx_q.size());
    end else begin
      checks++;
      if (tx_q[0] !== 8'h77 || tx_q[1] !== 8'h88) begin
        errors++;
        $display("FAIL busy_drop_tx: got %02h %02h, required 77 88", tx_q[0], tx_q[1]);
      end
    end
    tx_len = 3;
  endtask

  task automatic test_backpressure();
    req_q.delete(); tx_q.delete();
    nxt_code = 8'h3C; nxt_data = 8'hC3; rsp_lat = 1;
    ext_busy = 1'b1;
    send(8'h21);
    send(8'h02);
    tick(25);
    checks++;
    if (tx_q.size() != 0 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: tx=%0d busy=%b, required 0 bytes busy=1", tx_q.size(), o_Busy);
    end
    ext_busy = 1'b0;
    wait_idle("backpressure");
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h3C || tx_q[1] !== 8'hC3) begin
      errors++;
      $display("FAIL backpressure_tx: count=%0d, required 3C C3", tx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rsp_en = 1'b0;
    send(8'h01);
    send(8'h04);
    tick(5);
    i_Reset = 1'b1;
    tick(1);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    check_quiet("reset_mid");
    tick(1);
    req_q.delete(); tx_q.delete();
    force_rsp = 1'b1;
    force_done = 1'b1;
    tick(10);
    checks++;
    if (o_Busy !== 1'b0 || tx_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL reset_stale: busy=%b tx=%0d reqs=%0d, required 0/0/0", o_Busy, tx_q.size(), req_q.size());
    end
    rsp_en = 1'b1;
    run_txn("after_reset", 8'h0C, 8'h09, 3, 8'h01, 8'h02);
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout();
    rsp_en = 1'b0;
    run_txn("rsp_timeout", 8'h01, 8'h05, 1, 8'h00, 8'h00);
    rsp_en = 1'b1;
    run_txn("rsp_on_expiry", 8'h01, 8'h06, TO, 8'h42, 8'h24);
    run_txn("rsp_after_expiry", 8'h01, 8'h07, TO + 1, 8'h42, 8'h24);
  endtask

  task automatic test_interbyte();
    // gap of TO cycles between byte samples: still one request
    req_q.delete(); tx_q.delete();
    nxt_code = 8'h10; nxt_data = 8'h20; rsp_lat = 1;
    send(8'h01);
    tick(TO - 1);
    send(8'h06);
    wait_idle("gap_ok");
    checks++;
    if (req_q.size() != 1 || req_q[0] !== req_t'({8'h01, 5'd6})) begin
      errors++;
      $display("FAIL gap_ok_req: reqs=%0d, required one cmd=01 addr=6", req_q.size());
    end
    // one more cycle: partial request dropped silently
    req_q.delete(); tx_q.delete();
    send(8'h01);
    tick(TO);
    @(negedge i_Clock);
    checks++;
    if (o_Busy !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL gap_expire: busy=%b tx=%0d, required 0/0", o_Busy, tx_q.size());
    end
    tick(1);
    run_txn("after_gap", 8'h07, 8'h02, 2, 8'h99, 8'h66);
  endtask
`else
  task automatic test_no_timeout();
    req_q.delete(); tx_q.delete();
    rsp_en = 1'b0;
    send(8'h01);
    send(8'h05);
    tick(3 * TO);
    checks++;
    if (o_Busy !== 1'b1 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL no_timeout_wait: busy=%b tx=%0d, required 1/0", o_Busy, tx_q.size());
    end
    nxt_code = 8'hAB; nxt_data = 8'hCD;
    force_rsp = 1'b1;
    wait_idle("no_timeout");
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hAB || tx_q[1] !== 8'hCD) begin
      errors++;
      $display("FAIL no_timeout_tx: count=%0d, required AB CD", tx_q.size());
    end
    rsp_en = 1'b1;
    req_q.delete(); tx_q.delete();
    send(8'h09);
    tick(3 * TO);
    send(8'h03);
    wait_idle("long_gap");
    checks++;
    if (req_q.size() != 1 || req_q[0] !== req_t'({8'h09, 5'd3})) begin
      errors++;
      $display("FAIL long_gap_req: reqs=%0d, required one cmd=09 addr=3", req_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_valid();
    test_bad_addr();
    test_random();
    test_busy_drop();
    test_backpressure();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
    test_interbyte();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
Name: uart_cmd_controller

Overview:
Protocol sequencer between the UART pair (uart_rx/uart_tx) and up to NUM_UNITS sensor units on the FPGA. Collects a 2-byte request from the PC (command, then unit address), dispatches it to the addressed unit, waits for that unit's reply, and returns a 2-byte response (status, data) through uart_tx. Sits in the FPGA top between the UART instances and the sensor units. The UART receive path still feeds the display decoder in parallel.

Parameters:
NUM_UNITS, 32, number of addressable units; address values >= NUM_UNITS are invalid
ADDR_W, 5, width of unit address; must satisfy 2**ADDR_W >= NUM_UNITS
TIMEOUT_CYCLES, 2500000, response/inter-byte timeout in clocks (50 ms at 50 MHz)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Rx_DV  in  1  one-cycle strobe from uart_rx: byte valid
i_Rx_Byte  in  8  received byte from uart_rx
o_Tx_DV  out  1  one-cycle strobe to uart_tx: start byte
o_Tx_Byte  out  8  byte to transmit; held stable from strobe until i_Tx_Done
i_Tx_Active  in  1  uart_tx busy
i_Tx_Done  in  1  uart_tx one-cycle done strobe
o_Req_Valid  out  1  one-cycle request pulse to unit
o_Req_Addr  out  ADDR_W  addressed unit; held until response or timeout
o_Req_Cmd  out  8  command byte; held with o_Req_Addr
i_Rsp_Valid  in  1  one-cycle response strobe from addressed unit
i_Rsp_Code  in  8  unit status byte
i_Rsp_Data  in  8  unit data byte
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; o_Tx_DV=0, o_Tx_Byte=0, o_Req_Valid=0, o_Req_Addr=0, o_Req_Cmd=0, o_Busy=0; timer cleared. Reset mid-transaction abandons it without emitting a response. Any uart_tx byte already started completes on its own; a stale i_Tx_Done is ignored in IDLE.
- States: IDLE, WAIT_ADDR, ISSUE, WAIT_RSP, TX_B0, WAIT_TX0, TX_B1, WAIT_TX1.
- IDLE: on i_Rx_DV, latch cmd=i_Rx_Byte, clear timer -> WAIT_ADDR.
- WAIT_ADDR: on i_Rx_DV, latch addr=i_Rx_Byte[ADDR_W-1:0].
  - If i_Rx_Byte >= NUM_UNITS (full 8-bit compare): load code=ST_BAD_ADDR (0xFE), data=0x00 -> TX_B0; no request is issued.
  - Otherwise -> ISSUE.
- ISSUE: o_Req_Valid=1 for exactly this cycle; clear timer -> WAIT_RSP. Request-to-earliest-response latency is 1 cycle.
- WAIT_RSP: on i_Rsp_Valid, capture code/data -> TX_B0. i_Rsp_Valid is ignored in every other state.
- TX_B0: when i_Tx_Active=0, pulse o_Tx_DV with o_Tx_Byte=code -> WAIT_TX0. While i_Tx_Active=1, stay in TX_B0.
- WAIT_TX0: on i_Tx_Done -> TX_B1.
- TX_B1 / WAIT_TX1: same as TX_B0 / WAIT_TX0 with o_Tx_Byte=data; on i_Tx_Done -> IDLE.
- i_Rx_DV in ISSUE, WAIT_RSP, TX_*, WAIT_TX*: byte dropped; no queueing.
- A request's response is always exactly two bytes, status first.
- Timer width: clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Optional Feature:
Macro UART_CMD_TIMEOUT_EN.
- Defined:
  - In WAIT_ADDR, timer reaching TIMEOUT_CYCLES-1 with no i_Rx_DV -> IDLE silently; the partial request is discarded.
  - In WAIT_RSP, timer reaching TIMEOUT_CYCLES-1 -> code=ST_TIMEOUT (0xFF), data=0x00 -> TX_B0.
  - If i_Rsp_Valid (or i_Rx_DV) coincides with expiry, the valid input wins.
- Not defined: no timer logic; WAIT_ADDR and WAIT_RSP wait indefinitely (only i_Reset exits).

Decomposition:
- Shared include/package uart_cmd_defs: state encodings (3-bit localparams), ST_BAD_ADDR=8'hFE, ST_TIMEOUT=8'hFF, default TIMEOUT_CYCLES.
- One natural sub-module: uart_cmd_timer (clear, enable, expire-at-limit strobe, saturating). It is instantiated only under UART_CMD_TIMEOUT_EN.

Test Plan:
- Valid request: Rx 0x01 then 0x03; unit answers 4 cycles after o_Req_Valid with code 0x00, data 0x1A -> one o_Req_Valid pulse with Addr=3, Cmd=0x01; Tx bytes 0x00 then 0x1A; o_Busy falls after second i_Tx_Done.
- Bad address: Rx 0x02, 0x40 (NUM_UNITS=32) -> no o_Req_Valid; Tx 0xFE, 0x00.
- Timeout (macro on, TIMEOUT_CYCLES=100 in bench): Rx 0x01, 0x05, no response -> Tx 0xFF, 0x00 after 100 cycles in WAIT_RSP. Response arriving on the expiry cycle -> unit's bytes sent instead.
- Inter-byte timeout (macro on): Rx 0x01 only -> IDLE after 100 cycles, no Tx. Next Rx 0x07 is treated as a new command.
- Busy drop / TX backpressure: Rx 0x55 during WAIT_TX0 is ignored. With i_Tx_Active held high 20 cycles on entering TX_B0, o_Tx_DV is delayed until it drops.
- Reset mid-operation: assert i_Reset in WAIT_RSP -> all outputs 0 next cycle, state IDLE. A later i_Rsp_Valid and i_Tx_Done cause no activity.
